// File: rtl/stage_id.sv
// stage_id -- instruction-decode stage of the 5-stage pipeline.
//
// Owns the IF/ID register, the NREG x DATA_W register file, the main control
// decoder, load-use hazard detection and same-cycle branch/jump resolution.
// Produces the ID/EX pipeline register and the redirect/stall signals for
// fetch.
//
// Ports:
//   Clock_in, Reset_in          clock (rising edge), async active-high reset
//   IF_Instr, IF_PC_Next        fetched word and its PC+1 (word addressed)
//   WB_RegWrite/WB_Rd/WB_Data   register-file write port from write-back
//   CS_Branch, PC_MUX_IN        redirect fetch this cycle, and its target
//   CS_PC_Signal_write          PC/IF write enable (0 = stall)
//   EX_*                        ID/EX register: controls, operands, fields
//
// Optional feature macro: STAGE_ID_WB_BYPASS_EN
//   defined   -> a register read that collides with a WB write to the same
//                non-zero register returns WB_Data (operands and comparator)
//   undefined -> reads return the pre-write value
module stage_id #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                    Clock_in,
  input  logic                    Reset_in,
  input  logic [DATA_W-1:0]       IF_Instr,
  input  logic [DATA_W-1:0]       IF_PC_Next,
  input  logic                    WB_RegWrite,
  input  logic [$clog2(NREG)-1:0] WB_Rd,
  input  logic [DATA_W-1:0]       WB_Data,
  output logic                    CS_Branch,
  output logic [DATA_W-1:0]       PC_MUX_IN,
  output logic                    CS_PC_Signal_write,
  output logic                    EX_RegWrite,
  output logic                    EX_MemRead,
  output logic                    EX_MemWrite,
  output logic                    EX_ALUSrc,
  output logic                    EX_RegDst,
  output logic [1:0]              EX_ALUOp,
  output logic [DATA_W-1:0]       EX_RsData,
  output logic [DATA_W-1:0]       EX_RtData,
  output logic [DATA_W-1:0]       EX_Imm,
  output logic [$clog2(NREG)-1:0] EX_Rs,
  output logic [$clog2(NREG)-1:0] EX_Rt,
  output logic [$clog2(NREG)-1:0] EX_Rd,
  output logic [5:0]              EX_Funct
);

  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // IF/ID register
  logic [DATA_W-1:0] ifid_instr;
  logic [DATA_W-1:0] ifid_pc;

  // register file
  logic [DATA_W-1:0] regs [NREG];

  // instruction fields
  logic [5:0]        op;
  logic [AW-1:0]     rs, rt, rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sx;

  assign op     = ifid_instr[31:26];
  assign rs     = ifid_instr[25:21];
  assign rt     = ifid_instr[20:16];
  assign rd     = ifid_instr[15:11];
  assign funct  = ifid_instr[5:0];
  assign imm    = ifid_instr[15:0];
  assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};

  // ---------------------------------------------------------------------
  // register read (with optional write-back bypass)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rs_data, rt_data;

  always_comb begin
    rs_data = regs[rs];
    rt_data = regs[rt];
`ifdef STAGE_ID_WB_BYPASS_EN
    if (WB_RegWrite && (WB_Rd != '0) && (WB_Rd == rs)) rs_data = WB_Data;
    if (WB_RegWrite && (WB_Rd != '0) && (WB_Rd == rt)) rt_data = WB_Data;
`endif
    if (rs == '0) rs_data = '0;
    if (rt == '0) rt_data = '0;
  end

  // ---------------------------------------------------------------------
  // main control decoder
  // ---------------------------------------------------------------------
  ctrl_t ctrl;
  logic  uses_rs, uses_rt;

  always_comb begin
    ctrl    = '0;
    uses_rs = (op != OP_J);
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = 2'b10;
        uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: uses_rt = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // load-use hazard and branch resolution
  // ---------------------------------------------------------------------
  logic stall;
  logic taken;

  assign stall = EX_MemRead && (EX_Rt != '0) &&
                 ((uses_rs && (EX_Rt == rs)) || (uses_rt && (EX_Rt == rt)));

  always_comb begin
    taken     = 1'b0;
    PC_MUX_IN = '0;
    case (op)
      OP_BEQ: begin
        taken     = (rs_data == rt_data);
        PC_MUX_IN = ifid_pc + imm_sx;
      end
      OP_BNE: begin
        taken     = (rs_data != rt_data);
        PC_MUX_IN = ifid_pc + imm_sx;
      end
      OP_J: begin
        taken     = 1'b1;
        PC_MUX_IN = {ifid_pc[DATA_W-1:26], ifid_instr[25:0]};
      end
      default: ;
    endcase
  end

  // A stalled branch may still be reading a stale operand, so it must not
  // redirect; it re-resolves once the load result is available.
  assign CS_Branch          = taken && !stall;
  assign CS_PC_Signal_write = !stall;

  // ---------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock_in or posedge Reset_in) begin
    if (Reset_in) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (stall) begin
      ifid_instr <= ifid_instr;
      ifid_pc    <= ifid_pc;
    end else if (CS_Branch) begin
      ifid_instr <= '0;  // squash the wrong-path fetch
      ifid_pc    <= '0;
    end else begin
      ifid_instr <= IF_Instr;
      ifid_pc    <= IF_PC_Next;
    end
  end

  // ---------------------------------------------------------------------
  // register file (r0 is never written, so it stays 0 after reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock_in or posedge Reset_in) begin
    if (Reset_in) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_RegWrite && (WB_Rd != '0)) begin
      regs[WB_Rd] <= WB_Data;
    end
  end

  // ---------------------------------------------------------------------
  // ID/EX register; a stall inserts an all-zero bubble
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock_in or posedge Reset_in) begin
    if (Reset_in || stall) begin
      if (Reset_in) begin
        EX_RegWrite <= 1'b0;
        EX_MemRead  <= 1'b0;
        EX_MemWrite <= 1'b0;
        EX_ALUSrc   <= 1'b0;
        EX_RegDst   <= 1'b0;
        EX_ALUOp    <= '0;
        EX_RsData   <= '0;
        EX_RtData   <= '0;
        EX_Imm      <= '0;
        EX_Rs       <= '0;
        EX_Rt       <= '0;
        EX_Rd       <= '0;
        EX_Funct    <= '0;
      end else begin
        EX_RegWrite <= 1'b0;
        EX_MemRead  <= 1'b0;
        EX_MemWrite <= 1'b0;
        EX_ALUSrc   <= 1'b0;
        EX_RegDst   <= 1'b0;
        EX_ALUOp    <= '0;
        EX_RsData   <= '0;
        EX_RtData   <= '0;
        EX_Imm      <= '0;
        EX_Rs       <= '0;
        EX_Rt       <= '0;
        EX_Rd       <= '0;
        EX_Funct    <= '0;
      end
    end else begin
      EX_RegWrite <= ctrl.reg_write;
      EX_MemRead  <= ctrl.mem_read;
      EX_MemWrite <= ctrl.mem_write;
      EX_ALUSrc   <= ctrl.alu_src;
      EX_RegDst   <= ctrl.reg_dst;
      EX_ALUOp    <= ctrl.alu_op;
      EX_RsData   <= rs_data;
      EX_RtData   <= rt_data;
      EX_Imm      <= imm_sx;
      EX_Rs       <= rs;
      EX_Rt       <= rt;
      EX_Rd       <= rd;
      EX_Funct    <= funct;
    end
  end

endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id -- directed-vector bench for stage_id with hand-computed
// expected values. Inputs change and outputs are sampled 1ns after the rising
// edge. Prints one summary line: CHECKS <n> ERRORS <n>.
module tb_stage_id;

  logic        Clock_in = 1'b0;
  logic        Reset_in;
  logic [31:0] IF_Instr, IF_PC_Next;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;
  logic        CS_Branch, CS_PC_Signal_write;
  logic [31:0] PC_MUX_IN;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst;
  logic [1:0]  EX_ALUOp;
  logic [31:0] EX_RsData, EX_RtData, EX_Imm;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
  logic [5:0]  EX_Funct;

  int checks = 0;
  int errors = 0;

  stage_id dut (
    .Clock_in(Clock_in), .Reset_in(Reset_in),
    .IF_Instr(IF_Instr), .IF_PC_Next(IF_PC_Next),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .CS_Branch(CS_Branch), .PC_MUX_IN(PC_MUX_IN),
    .CS_PC_Signal_write(CS_PC_Signal_write),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
    .EX_ALUOp(EX_ALUOp), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
    .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_Funct(EX_Funct)
  );

  always #5 Clock_in = ~Clock_in;

  // instruction words
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ADDI_1   = 32'h2001_0005; // addi r1,r0,5
  localparam logic [31:0] ADD_322  = 32'h0042_1820; // add r3,r2,r2
  localparam logic [31:0] ADD_302  = 32'h0002_1820; // add r3,r0,r2
  localparam logic [31:0] LW_4     = 32'h8C24_0000; // lw r4,0(r1)
  localparam logic [31:0] ADD_541  = 32'h0081_2820; // add r5,r4,r1
  localparam logic [31:0] BEQ_22   = 32'h1042_FFFE; // beq r2,r2,-2
  localparam logic [31:0] BEQ_12   = 32'h1022_FFFE; // beq r1,r2,-2
  localparam logic [31:0] BNE_12   = 32'h1422_0003; // bne r1,r2,+3
  localparam logic [31:0] BEQ_44   = 32'h1084_0001; // beq r4,r4,+1
  localparam logic [31:0] J_20     = 32'h0800_0020; // j 0x20
  localparam logic [31:0] ADD_760  = 32'h00C0_3820; // add r7,r6,r0

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock_in);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite = 1'b1; WB_Rd = r; WB_Data = d;
    tick();
    WB_RegWrite = 1'b0; WB_Rd = '0; WB_Data = '0;
  endtask

  // present one word, then NOPs until it has reached ID/EX
  task automatic issue(input logic [31:0] w, input logic [31:0] pc);
    IF_Instr = w; IF_PC_Next = pc;
    tick();
    IF_Instr = NOP; IF_PC_Next = '0;
    tick();
  endtask

  initial begin
    Reset_in = 1'b1; IF_Instr = NOP; IF_PC_Next = '0;
    WB_RegWrite = 1'b0; WB_Rd = '0; WB_Data = '0;
    #12;
    chk("rst_ex_regwrite", 32'(EX_RegWrite), 0);
    chk("rst_ex_rsdata", EX_RsData, 0);
    chk("rst_pcwrite", 32'(CS_PC_Signal_write), 1);
    chk("rst_branch", 32'(CS_Branch), 0);
    chk("rst_target", PC_MUX_IN, 0);
    @(negedge Clock_in); Reset_in = 1'b0;
    @(posedge Clock_in); #1;

    // ADDI decode
    issue(ADDI_1, 32'h1);
    chk("addi_regwrite", 32'(EX_RegWrite), 1);
    chk("addi_alusrc", 32'(EX_ALUSrc), 1);
    chk("addi_imm", EX_Imm, 32'h5);
    chk("addi_rt", 32'(EX_Rt), 1);
    chk("addi_aluop", 32'(EX_ALUOp), 0);

    // register file write/read, r0 hard-wired
    wb_write(5'd2, 32'h1234);
    wb_write(5'd1, 32'h5);
    issue(ADD_322, 32'h2);
    chk("add_rsdata", EX_RsData, 32'h1234);
    chk("add_rtdata", EX_RtData, 32'h1234);
    chk("add_aluop", 32'(EX_ALUOp), 2);
    chk("add_regdst", 32'(EX_RegDst), 1);
    chk("add_funct", 32'(EX_Funct), 32'h20);
    wb_write(5'd0, 32'hDEAD);
    issue(ADD_302, 32'h3);
    chk("r0_rsdata", EX_RsData, 0);
    chk("r0_rtdata", EX_RtData, 32'h1234);

    // load-use: one stall cycle, one bubble, then ADD issues
    IF_Instr = LW_4; tick();
    IF_Instr = ADD_541; tick();
    IF_Instr = NOP;
    chk("lu_memread", 32'(EX_MemRead), 1);
    chk("lu_stall", 32'(CS_PC_Signal_write), 0);
    tick();
    chk("lu_release", 32'(CS_PC_Signal_write), 1);
    chk("lu_bubble_rw", 32'(EX_RegWrite), 0);
    chk("lu_bubble_mr", 32'(EX_MemRead), 0);
    chk("lu_bubble_op", 32'(EX_ALUOp), 0);
    tick();
    chk("lu_add_rw", 32'(EX_RegWrite), 1);
    chk("lu_add_rs", 32'(EX_Rs), 4);
    chk("lu_add_rd", 32'(EX_Rd), 5);
    chk("lu_add_rtdata", EX_RtData, 32'h5);
    tick();

    // BEQ taken, wrong-path word squashed
    IF_Instr = BEQ_22; IF_PC_Next = 32'h10; tick();
    IF_Instr = ADDI_1; IF_PC_Next = 32'h11;
    chk("beq_taken", 32'(CS_Branch), 1);
    chk("beq_target", PC_MUX_IN, 32'h0E);
    tick();
    IF_Instr = NOP; IF_PC_Next = '0;
    chk("flush_branch", 32'(CS_Branch), 0);
    tick();
    chk("flush_alusrc", 32'(EX_ALUSrc), 0);
    chk("flush_imm", EX_Imm, 0);
    chk("flush_rt", 32'(EX_Rt), 0);

    // BEQ not taken, BNE taken
    IF_Instr = BEQ_12; IF_PC_Next = 32'h10; tick();
    IF_Instr = NOP; IF_PC_Next = '0;
    chk("beq_ne_branch", 32'(CS_Branch), 0);
    tick();
    IF_Instr = BNE_12; IF_PC_Next = 32'h20; tick();
    IF_Instr = NOP; IF_PC_Next = '0;
    chk("bne_taken", 32'(CS_Branch), 1);
    chk("bne_target", PC_MUX_IN, 32'h23);
    tick();

    // J keeps PC[31:26]
    IF_Instr = J_20; IF_PC_Next = 32'h0400_0001; tick();
    IF_Instr = NOP; IF_PC_Next = '0;
    chk("j_taken", 32'(CS_Branch), 1);
    chk("j_target", PC_MUX_IN, 32'h0400_0020);
    tick();

    // stall beats redirect; branch resolves the following cycle
    IF_Instr = LW_4; tick();
    IF_Instr = BEQ_44; IF_PC_Next = 32'h30; tick();
    IF_Instr = NOP; IF_PC_Next = '0;
    chk("sb_stall", 32'(CS_PC_Signal_write), 0);
    chk("sb_nobranch", 32'(CS_Branch), 0);
    tick();
    chk("sb_branch", 32'(CS_Branch), 1);
    chk("sb_target", PC_MUX_IN, 32'h31);
    tick();
    tick();

    // same-cycle write-back vs read
    wb_write(5'd6, 32'h99);
    IF_Instr = ADD_760; tick();
    IF_Instr = NOP;
    WB_RegWrite = 1'b1; WB_Rd = 5'd6; WB_Data = 32'h7;
    tick();
    WB_RegWrite = 1'b0; WB_Rd = '0; WB_Data = '0;
`ifdef STAGE_ID_WB_BYPASS_EN
    chk("wb_same_cycle", EX_RsData, 32'h7);
`else
    chk("wb_same_cycle", EX_RsData, 32'h99);
`endif
    tick();

    // reset in the middle of a stall
    IF_Instr = LW_4; tick();
    IF_Instr = ADD_541; tick();
    IF_Instr = NOP;
    chk("mr_stall", 32'(CS_PC_Signal_write), 0);
    Reset_in = 1'b1; #1;
    chk("mr_memread", 32'(EX_MemRead), 0);
    chk("mr_pcwrite", 32'(CS_PC_Signal_write), 1);
    chk("mr_rt", 32'(EX_Rt), 0);
    @(negedge Clock_in); Reset_in = 1'b0;
    @(posedge Clock_in); #1;
    issue(ADD_322, 32'h2);
    chk("mr_regs_cleared", EX_RsData, 0);
    chk("mr_add_regwrite", 32'(EX_RegWrite), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
